// File: rtl/mod_time_counter_if.sv
// Control and status bundle for mod_time_counter.
// The bcd member exists only when MOD_TIME_BCD_EN is defined.
interface mod_time_counter_if #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned BCD_DIGITS = 2
);
    logic             enable;
    logic             tick;
    logic             dir;
    logic             sat_mode;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic             carry_out;
    logic             at_limit;
`ifdef MOD_TIME_BCD_EN
    logic [4*BCD_DIGITS-1:0] bcd;
`endif

    modport master (
        output enable, tick, dir, sat_mode, clear, load, load_value,
`ifdef MOD_TIME_BCD_EN
        input  bcd,
`endif
        input  count, carry_out, at_limit
    );

    modport slave (
        input  enable, tick, dir, sat_mode, clear, load, load_value,
`ifdef MOD_TIME_BCD_EN
        output bcd,
`endif
        output count, carry_out, at_limit
    );
endinterface

// File: rtl/mod_time_counter.sv
// Modulo-N time-field counter: up/down, wrap or saturate, synchronous
// clear/load with clamping, and a combinational carry for zero-latency
// chaining (seconds -> minutes -> hours).
// Optional registered BCD output is enabled with the macro MOD_TIME_BCD_EN.
module mod_time_counter #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MAX_COUNT  = 99,
    parameter int unsigned BCD_DIGITS = 2
) (
    input logic             clk,
    input logic             rst,
    mod_time_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_limit;
    logic             advance;
    logic             carry;

    // Limit detection and carry; carry is suppressed while in reset
    always_comb begin
        at_limit = bus.dir ? (count_q == '0) : (count_q == MAX_VAL);
        advance  = bus.enable & bus.tick & ~bus.clear & ~bus.load;
        carry    = advance & ~bus.sat_mode & at_limit & ~rst;
    end

    // Next-count selection: clear > load > advance > hold
    always_comb begin
        count_d = count_q;
        if (bus.clear) begin
            count_d = '0;
        end else if (bus.load) begin
            count_d = (bus.load_value > MAX_VAL) ? MAX_VAL : bus.load_value;
        end else if (advance) begin
            if (count_q > MAX_VAL) begin
                count_d = '0;
            end else if (!bus.dir) begin
                if (count_q == MAX_VAL) begin
                    count_d = bus.sat_mode ? MAX_VAL : '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = bus.sat_mode ? '0 : MAX_VAL;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.count     = count_q;
    assign bus.at_limit  = at_limit;
    assign bus.carry_out = carry;

`ifdef MOD_TIME_BCD_EN
    localparam int unsigned BCD_W = 4 * BCD_DIGITS;

    logic [BCD_W-1:0]       bcd_q;
    logic [BCD_W-1:0]       bcd_d;
    logic [BCD_W+WIDTH-1:0] scratch;

    // Shift-add-3 conversion of the next count so bcd aligns with count
    always_comb begin
        scratch = '0;
        scratch[WIDTH-1:0] = count_d;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
                if (scratch[WIDTH+4*d +: 4] >= 4'd5) begin
                    scratch[WIDTH+4*d +: 4] = scratch[WIDTH+4*d +: 4] + 4'd3;
                end
            end
            scratch = scratch << 1;
        end
        bcd_d = scratch[WIDTH +: BCD_W];
    end

    // BCD register, updated on the same edge as count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q <= '0;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign bus.bcd = bcd_q;
`endif
endmodule

// File: tb/tb_mod_time_counter.sv
// Self-checking bench for mod_time_counter: two chained instances
// (MAX_COUNT 59 feeding MAX_COUNT 99), directed cases then randomized
// traffic checked against an arithmetic reference model.
module tb_mod_time_counter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic chain_sel = 1'b0;
    logic tick_min = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mod_time_counter_if #(.WIDTH(8), .BCD_DIGITS(2)) if_sec ();
    mod_time_counter_if #(.WIDTH(8), .BCD_DIGITS(2)) if_min ();

    assign if_min.tick = chain_sel ? if_sec.carry_out : tick_min;

    mod_time_counter #(.WIDTH(8), .MAX_COUNT(59), .BCD_DIGITS(2)) u_sec (
        .clk(clk), .rst(rst), .bus(if_sec)
    );
    mod_time_counter #(.WIDTH(8), .MAX_COUNT(99), .BCD_DIGITS(2)) u_min (
        .clk(clk), .rst(rst), .bus(if_min)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model
    function automatic int m_next(int cur, int mx, bit clr, bit ld, int lv,
                                  bit en, bit tk, bit dr, bit st);
        if (clr) return 0;
        if (ld) return (lv > mx) ? mx : lv;
        if (!(en && tk)) return cur;
        if (cur > mx) return 0;
        if (!dr) return (cur == mx) ? (st ? mx : 0) : cur + 1;
        return (cur == 0) ? (st ? 0 : mx) : cur - 1;
    endfunction

    function automatic bit m_limit(int cur, int mx, bit dr);
        return dr ? (cur == 0) : (cur == mx);
    endfunction

    function automatic bit m_carry(int cur, int mx, bit clr, bit ld,
                                   bit en, bit tk, bit dr, bit st);
        return en && tk && !clr && !ld && !st && m_limit(cur, mx, dr);
    endfunction

    function automatic int m_bcd(int v);
        return ((v / 10) * 16) + (v % 10);
    endfunction

    task automatic drive_sec(bit clr, bit ld, int lv, bit en, bit tk, bit dr, bit st);
        if_sec.clear = clr; if_sec.load = ld; if_sec.load_value = 8'(lv);
        if_sec.enable = en; if_sec.tick = tk; if_sec.dir = dr; if_sec.sat_mode = st;
    endtask

    task automatic drive_min(bit clr, bit ld, int lv, bit en, bit tk, bit dr, bit st);
        if_min.clear = clr; if_min.load = ld; if_min.load_value = 8'(lv);
        if_min.enable = en; tick_min = tk; if_min.dir = dr; if_min.sat_mode = st;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int m_sec, m_min;
    bit s_clr, s_ld, s_en, s_tk, s_dr, s_st;
    bit n_clr, n_ld, n_en, n_tk, n_dr, n_st, n_ch, tk_eff, c_sec, c_min;
    int s_lv, n_lv;

    initial begin
        drive_sec(0, 0, 0, 0, 0, 0, 0);
        drive_min(0, 0, 0, 1, 1, 1, 0);
        rst = 1'b1;
        #12;
        // Reset state; carry must stay low while in reset even with dir=1 at 0
        check("rst_count", if_min.count, 0);
        check("rst_carry", if_min.carry_out, 0);
        check("rst_limit_down", if_min.at_limit, 1);
`ifdef MOD_TIME_BCD_EN
        check("rst_bcd", if_min.bcd, 0);
`endif
        drive_min(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("rst_limit_up", if_min.at_limit, 0);
        rst = 1'b0;
        cyc();

        // Load 98, two ticks, wrap with same-cycle carry
        drive_min(0, 1, 98, 1, 0, 0, 0);
        cyc();
        check("load98", if_min.count, 98);
        drive_min(0, 0, 0, 1, 1, 0, 0);
        #1;
        check("tick1_carry", if_min.carry_out, 0);
        cyc();
        check("tick1_count", if_min.count, 99);
        check("tick1_limit", if_min.at_limit, 1);
        check("tick2_carry", if_min.carry_out, 1);
        cyc();
        check("wrap_count", if_min.count, 0);
`ifdef MOD_TIME_BCD_EN
        check("wrap_bcd", if_min.bcd, 0);
`endif

        // Down wrap then saturate at 0
        drive_min(0, 0, 0, 1, 1, 1, 0);
        #1;
        check("down_carry", if_min.carry_out, 1);
        cyc();
        check("down_wrap", if_min.count, 99);
        drive_min(1, 0, 0, 1, 0, 1, 0);
        cyc();
        check("clear", if_min.count, 0);
        drive_min(0, 0, 0, 1, 1, 1, 1);
        #1;
        check("sat_carry", if_min.carry_out, 0);
        cyc();
        check("sat_hold", if_min.count, 0);

        // Clamped load beats tick; clear beats load
        drive_min(0, 1, 150, 1, 1, 0, 0);
        #1;
        check("clamp_carry", if_min.carry_out, 0);
        cyc();
        check("clamp_count", if_min.count, 99);
`ifdef MOD_TIME_BCD_EN
        check("clamp_bcd", if_min.bcd, 32'h99);
`endif
        drive_min(1, 1, 50, 1, 1, 0, 0);
        #1;
        check("clr_ld_carry", if_min.carry_out, 0);
        cyc();
        check("clr_ld_count", if_min.count, 0);

        // Chain: seconds at 59, minutes at 5, one tick rolls both
        drive_sec(0, 1, 59, 1, 0, 0, 0);
        drive_min(0, 1, 5, 1, 0, 0, 0);
        cyc();
        drive_sec(0, 0, 0, 1, 1, 0, 0);
        drive_min(0, 0, 0, 1, 0, 0, 0);
        chain_sel = 1'b1;
        #1;
        check("chain_carry", if_sec.carry_out, 1);
        cyc();
        check("chain_sec", if_sec.count, 0);
        check("chain_min", if_min.count, 6);
        drive_sec(0, 0, 0, 0, 0, 0, 0);
        chain_sel = 1'b0;

        // Asynchronous reset mid-cycle
        drive_min(0, 1, 42, 1, 0, 0, 0);
        cyc();
        check("load42", if_min.count, 42);
`ifdef MOD_TIME_BCD_EN
        drive_min(0, 1, 47, 1, 0, 0, 0);
        cyc();
        check("bcd47", if_min.bcd, 32'h47);
        check("bcd47_count", if_min.count, 47);
        drive_min(0, 1, 42, 1, 0, 0, 0);
        cyc();
`endif
        drive_min(0, 0, 0, 1, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", if_min.count, 0);
        #1;
        rst = 1'b0;
        cyc();

        // enable low blocks ticks
        drive_min(0, 1, 42, 1, 0, 0, 0);
        cyc();
        drive_min(0, 0, 0, 0, 1, 0, 0);
        repeat (3) cyc();
        check("en_hold", if_min.count, 42);
        check("en_carry", if_min.carry_out, 0);

        // Randomized phase against the reference model
        rst = 1'b1;
        #1;
        rst = 1'b0;
        m_sec = 0;
        m_min = 0;
        for (int i = 0; i < 600; i++) begin
            s_clr = ($urandom_range(0, 31) == 0);
            s_ld  = ($urandom_range(0, 15) == 0);
            s_lv  = int'($urandom_range(0, 255));
            s_en  = ($urandom_range(0, 7) != 0);
            s_tk  = ($urandom_range(0, 3) != 0);
            s_dr  = ($urandom_range(0, 5) == 0);
            s_st  = ($urandom_range(0, 7) == 0);
            n_clr = ($urandom_range(0, 31) == 0);
            n_ld  = ($urandom_range(0, 15) == 0);
            n_lv  = int'($urandom_range(0, 255));
            n_en  = ($urandom_range(0, 7) != 0);
            n_tk  = ($urandom_range(0, 1) != 0);
            n_dr  = ($urandom_range(0, 3) == 0);
            n_st  = ($urandom_range(0, 7) == 0);
            n_ch  = ($urandom_range(0, 1) != 0);
            drive_sec(s_clr, s_ld, s_lv, s_en, s_tk, s_dr, s_st);
            drive_min(n_clr, n_ld, n_lv, n_en, n_tk, n_dr, n_st);
            chain_sel = n_ch;
            #1;
            c_sec  = m_carry(m_sec, 59, s_clr, s_ld, s_en, s_tk, s_dr, s_st);
            tk_eff = n_ch ? c_sec : n_tk;
            c_min  = m_carry(m_min, 99, n_clr, n_ld, n_en, tk_eff, n_dr, n_st);
            check("r_sec_limit", if_sec.at_limit, m_limit(m_sec, 59, s_dr));
            check("r_sec_carry", if_sec.carry_out, c_sec);
            check("r_min_limit", if_min.at_limit, m_limit(m_min, 99, n_dr));
            check("r_min_carry", if_min.carry_out, c_min);
            m_sec = m_next(m_sec, 59, s_clr, s_ld, s_lv, s_en, s_tk, s_dr, s_st);
            m_min = m_next(m_min, 99, n_clr, n_ld, n_lv, n_en, tk_eff, n_dr, n_st);
            cyc();
            check("r_sec_count", if_sec.count, m_sec);
            check("r_min_count", if_min.count, m_min);
`ifdef MOD_TIME_BCD_EN
            check("r_sec_bcd", if_sec.bcd, m_bcd(m_sec));
            check("r_min_bcd", if_min.bcd, m_bcd(m_min));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
